// File: rtl/reaction_bcd_timer_if.sv
// Control/status bundle between the reaction-game controller and the BCD timing stage.
interface reaction_bcd_timer_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  show_best;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  running;
    logic                  done;
    logic                  overflow;
    logic                  best_valid;

    modport master (
        output start, stop, clear, show_best,
        input  disp_bcd, running, done, overflow, best_valid
    );

    modport slave (
        input  start, stop, clear, show_best,
        output disp_bcd, running, done, overflow, best_valid
    );
endinterface

// File: rtl/reaction_bcd_timer.sv
// BCD millisecond reaction timer with freeze, saturation and optional best-time tracking.
// Optional feature macro: BEST_SCORE_EN (best register, compare and show_best select).
module reaction_bcd_timer #(
    parameter int TICK_DIV = 50000,
    parameter int DIGITS   = 4
) (
    input logic               clock,
    input logic               reset,
    reaction_bcd_timer_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0]  FULL     = {DIGITS{4'd9}};
    localparam logic [PW-1:0] TICK_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD, OVER} state_t;

    state_t         state;
    logic [PW-1:0]  presc;
    logic [W-1:0]   count;
    logic           running_r;
    logic           done_r;
    logic           overflow_r;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            presc      <= '0;
            count      <= '0;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= COUNT;
                        presc     <= '0;
                        count     <= '0;
                        running_r <= 1'b1;
                    end
                end
                COUNT: begin
                    // clear beats stop beats tick
                    if (bus.clear) begin
                        state     <= IDLE;
                        count     <= '0;
                        running_r <= 1'b0;
                    end else if (bus.stop) begin
                        state     <= HOLD;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else if (presc == TICK_TOP) begin
                        presc <= '0;
                        if (count == FULL) begin
                            state      <= OVER;
                            running_r  <= 1'b0;
                            overflow_r <= 1'b1;
                        end else begin
                            count <= bcd_inc(count);
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                HOLD: begin
                    if (bus.clear) begin
                        state  <= IDLE;
                        count  <= '0;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    if (bus.clear) begin
                        state      <= IDLE;
                        count      <= '0;
                        overflow_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.running  = running_r;
    assign bus.done     = done_r;
    assign bus.overflow = overflow_r;

`ifdef BEST_SCORE_EN
    logic [W-1:0] best;
    logic         best_valid_r;

    // Digit-wise BCD magnitude compare, most-significant digit decides first.
    function automatic logic bcd_less(input logic [W-1:0] a, input logic [W-1:0] b);
        logic lt;
        logic decided;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                lt      = (a[4*i +: 4] < b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return lt;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            best         <= FULL;
            best_valid_r <= 1'b0;
        end else if ((state == COUNT) && !bus.clear && bus.stop &&
                     (!best_valid_r || bcd_less(count, best))) begin
            best         <= count;
            best_valid_r <= 1'b1;
        end
    end

    assign bus.best_valid = best_valid_r;
    assign bus.disp_bcd   = (bus.show_best && best_valid_r) ? best : count;
`else
    logic unused_show_best;
    assign unused_show_best = bus.show_best;
    assign bus.best_valid   = 1'b0;
    assign bus.disp_bcd     = count;
`endif
endmodule

// File: tb/tb_reaction_bcd_timer.sv
// Randomized and directed bench for reaction_bcd_timer against an integer-millisecond model.
module tb_reaction_bcd_timer;
    localparam int TICK_DIV = 4;
    localparam int DIGITS   = 4;
    localparam int FULL_N   = 9999;
    localparam int M_IDLE = 0, M_COUNT = 1, M_HOLD = 2, M_OVER = 3;
`ifdef BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    reaction_bcd_timer_if #(.DIGITS(DIGITS)) bus ();

    reaction_bcd_timer #(.TICK_DIV(TICK_DIV), .DIGITS(DIGITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Model: elapsed cycles in the run give the millisecond count by division.
    int m_state = M_IDLE;
    int m_elapsed = 0;
    int m_count = 0;
    int m_best = FULL_N;
    bit m_bv = 1'b0;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          v;
        v = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {12'd0, bus.running, bus.done, bus.overflow, bus.best_valid, bus.disp_bcd};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [15:0] d;
        d = (BEST_EN && bus.show_best && m_bv) ? to_bcd(m_best) : to_bcd(m_count);
        return {12'd0, m_state == M_COUNT, m_state == M_HOLD, m_state == M_OVER,
                BEST_EN && m_bv, d};
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic p, input logic c);
        if (!r) begin
            m_state = M_IDLE; m_elapsed = 0; m_count = 0; m_best = FULL_N; m_bv = 1'b0;
        end else if (m_state == M_IDLE) begin
            if (s) begin m_state = M_COUNT; m_elapsed = 0; m_count = 0; end
        end else if (m_state == M_COUNT) begin
            if (c) begin
                m_state = M_IDLE; m_count = 0;
            end else if (p) begin
                m_state = M_HOLD;
                if (!m_bv || m_count < m_best) begin m_best = m_count; m_bv = 1'b1; end
            end else begin
                m_elapsed++;
                if (m_elapsed / TICK_DIV > FULL_N) begin
                    m_state = M_OVER; m_count = FULL_N;
                end else begin
                    m_count = m_elapsed / TICK_DIV;
                end
            end
        end else if (c) begin
            m_state = M_IDLE; m_count = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic p, input logic c);
        reset = r; bus.start = s; bus.stop = p; bus.clear = c;
        @(posedge clock);
        model_edge(r, s, p, c);
        #1;
        chk("cycle", dut_vec(), model_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic show(input logic v);
        bus.show_best = v;
        #1;
        chk("show", dut_vec(), model_vec());
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.show_best = 1'b0;

        // 1: reset
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_out", dut_vec(), 32'd0);

        // 2: first run to 37
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4 * 37);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("t2_done", {31'd0, bus.done}, 32'd1);
        chk("t2_disp", {16'd0, bus.disp_bcd}, 32'h0037);
        chk("t2_bv", {31'd0, bus.best_valid}, {31'd0, BEST_EN});
        cyc(1'b1, 1'b0, 1'b0, 1'b1);

        // 3: slower run leaves best alone
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4 * 52);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        show(1'b1);
        chk("t3_best", {16'd0, bus.disp_bcd}, BEST_EN ? 32'h0037 : 32'h0052);
        show(1'b0);
        chk("t3_cur", {16'd0, bus.disp_bcd}, 32'h0052);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);

        // 4: carry and stop on a tick edge
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(36);
        chk("t4_09", {16'd0, bus.disp_bcd}, 32'h0009);
        idle(4);
        chk("t4_10", {16'd0, bus.disp_bcd}, 32'h0010);
        idle(7);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_frozen", {16'd0, bus.disp_bcd}, 32'h0011);
        show(1'b1);
        chk("t4_best", {16'd0, bus.disp_bcd}, 32'h0011);
        show(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);

        // 5: saturation
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4 * 10000);
        chk("t5_ovf", {31'd0, bus.overflow}, 32'd1);
        chk("t5_disp", {16'd0, bus.disp_bcd}, 32'h9999);
        show(1'b1);
        chk("t5_best", {16'd0, bus.disp_bcd}, BEST_EN ? 32'h0011 : 32'h9999);
        show(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_clr", dut_vec(), {28'd0, BEST_EN, 16'h0000});

        // 6: stop and clear together
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(10);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t6_idle", {29'd0, bus.running, bus.done, bus.overflow}, 32'd0);
        show(1'b1);
        chk("t6_best", {16'd0, bus.disp_bcd}, BEST_EN ? 32'h0011 : 32'h0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 16 == 0) bus.show_best = ~bus.show_best;
            cyc(($urandom % 500) != 0, ($urandom % 8) == 0,
                ($urandom % 40) == 0, ($urandom % 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
